// File: rtl/gpio_arb_pkg.sv
// Shared types and default sizes for the GPIO pin-bank arbiter.
package gpio_arb_pkg;

  localparam int unsigned DEF_NUM_REQ = 4;
  localparam int unsigned DEF_PIN_W   = 34;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_TURN  = 2'd2
  } arb_state_e;

  // Counter width that stays at least one bit for degenerate sizes.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester after last_owner, wrapping.
module rr_arbiter
  import gpio_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEF_NUM_REQ,
  parameter int unsigned IDX_W   = cnt_w(DEF_NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_owner,
  output logic [IDX_W-1:0]   winner,
  output logic               any_req
);

  int unsigned cand;
  logic        found;

  always_comb begin
    winner = '0;
    found  = 1'b0;
    cand   = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = (32'(last_owner) + k) % NUM_REQ;
      if (!found && req[IDX_W'(cand)]) begin
        winner = IDX_W'(cand);
        found  = 1'b1;
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/gpio_arbiter.sv
// Time-shared GPIO pin bank: round-robin ownership with hold-time preemption
// and a floated turnaround between owners.
module gpio_arbiter
  import gpio_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ  = DEF_NUM_REQ,
  parameter int unsigned PIN_W    = DEF_PIN_W,
  parameter int unsigned MAX_HOLD = 256,
  parameter int unsigned TURN_CYC = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*PIN_W-1:0]   req_out,
  input  logic [NUM_REQ*PIN_W-1:0]   req_oe,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [PIN_W-1:0]           gpio_out,
  output logic [PIN_W-1:0]           gpio_oe,
  output logic [$clog2(NUM_REQ)-1:0] owner,
  output logic                       owner_valid,
  output logic                       preempt
);

  localparam int unsigned OWN_W  = $clog2(NUM_REQ);
  localparam int unsigned HOLD_W = cnt_w(MAX_HOLD);
  localparam int unsigned TURN_W = cnt_w(TURN_CYC);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
  localparam logic [TURN_W-1:0] TURN_LAST = TURN_W'(TURN_CYC - 1);

  arb_state_e         state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [OWN_W-1:0]   owner_q, owner_d;
  logic [OWN_W-1:0]   last_owner_q, last_owner_d;
  logic               owner_valid_q, owner_valid_d;
  logic               preempt_q, preempt_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [TURN_W-1:0]  turn_q, turn_d;
  logic [PIN_W-1:0]   gpio_out_q, gpio_out_d;
  logic [PIN_W-1:0]   gpio_oe_q, gpio_oe_d;

  logic [OWN_W-1:0]   winner;
  logic               any_req;
  logic               others_pending;
  logic [PIN_W-1:0]   out_slice [NUM_REQ];
  logic [PIN_W-1:0]   oe_slice  [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
    assign out_slice[i] = req_out[i*PIN_W +: PIN_W];
    assign oe_slice[i]  = req_oe[i*PIN_W +: PIN_W];
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (OWN_W)
  ) u_rr (
    .req        (req),
    .last_owner (last_owner_q),
    .winner     (winner),
    .any_req    (any_req)
  );

  assign others_pending = |(req & ~gnt_q);

  // Next state and registered outputs; pads float whenever nobody owns the bank.
  always_comb begin
    state_d       = state_q;
    gnt_d         = gnt_q;
    owner_d       = owner_q;
    last_owner_d  = last_owner_q;
    owner_valid_d = owner_valid_q;
    preempt_d     = 1'b0;
    hold_d        = hold_q;
    turn_d        = turn_q;
    gpio_out_d    = gpio_out_q;
    gpio_oe_d     = gpio_oe_q;

    case (state_q)
      ST_IDLE: begin
        gpio_out_d = '0;
        gpio_oe_d  = '1;
        if (any_req) begin
          state_d       = ST_GRANT;
          gnt_d         = NUM_REQ'(1) << winner;
          owner_d       = winner;
          last_owner_d  = winner;
          owner_valid_d = 1'b1;
          hold_d        = '0;
        end
      end

      ST_GRANT: begin
        gpio_out_d = out_slice[owner_q];
        gpio_oe_d  = oe_slice[owner_q];
        if (hold_q != HOLD_LAST) begin
          hold_d = hold_q + HOLD_W'(1);
        end
        // Release wins over a simultaneous timeout, so it never preempts.
        if (!req[owner_q] || ((hold_q == HOLD_LAST) && others_pending)) begin
          state_d       = ST_TURN;
          preempt_d     = req[owner_q];
          gnt_d         = '0;
          owner_valid_d = 1'b0;
          gpio_out_d    = '0;
          gpio_oe_d     = '1;
          hold_d        = '0;
          turn_d        = '0;
        end
      end

      ST_TURN: begin
        if (turn_q == TURN_LAST) begin
          state_d = ST_IDLE;
        end else begin
          turn_d = turn_q + TURN_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      gnt_q         <= '0;
      owner_q       <= '0;
      last_owner_q  <= OWN_W'(NUM_REQ - 1);
      owner_valid_q <= 1'b0;
      preempt_q     <= 1'b0;
      hold_q        <= '0;
      turn_q        <= '0;
      gpio_out_q    <= '0;
      gpio_oe_q     <= '1;
    end else begin
      state_q       <= state_d;
      gnt_q         <= gnt_d;
      owner_q       <= owner_d;
      last_owner_q  <= last_owner_d;
      owner_valid_q <= owner_valid_d;
      preempt_q     <= preempt_d;
      hold_q        <= hold_d;
      turn_q        <= turn_d;
      gpio_out_q    <= gpio_out_d;
      gpio_oe_q     <= gpio_oe_d;
    end
  end

  assign gnt         = gnt_q;
  assign owner       = owner_q;
  assign owner_valid = owner_valid_q;
  assign preempt     = preempt_q;
  assign gpio_out    = gpio_out_q;
  assign gpio_oe     = gpio_oe_q;

endmodule

// File: tb/tb_gpio_arbiter.sv
// Self-checking bench for gpio_arbiter: directed scenarios, a handover table
// and randomized traffic against a behavioural ownership model.
module tb_gpio_arbiter;

  localparam int unsigned N   = 4;
  localparam int unsigned PW  = 34;
  localparam int unsigned MH  = 4;
  localparam int unsigned TC  = 2;
  localparam logic [PW-1:0] ONES = '1;

  logic                clk;
  logic                rst;
  logic [N-1:0]        req;
  logic [N*PW-1:0]     req_out;
  logic [N*PW-1:0]     req_oe;
  logic [N-1:0]        gnt;
  logic [PW-1:0]       gpio_out;
  logic [PW-1:0]       gpio_oe;
  logic [1:0]          owner;
  logic                owner_valid;
  logic                preempt;

  int total;
  int bad;
  bit chk_en;

  // Model: who owns the bank, for how long, and how much float time remains.
  int          m_owner;
  int          m_held;
  int          m_gap;
  int          m_last;
  logic        m_pre;
  logic [PW-1:0] m_out;
  logic [PW-1:0] m_oe;

  typedef struct packed {
    logic [N-1:0]  gnt;
    logic          pre;
    logic          oe1;
    logic [PW-1:0] out;
  } vec_t;

  vec_t          tbl [35];
  logic [PW-1:0] pv  [N];

  gpio_arbiter #(
    .NUM_REQ  (N),
    .PIN_W    (PW),
    .MAX_HOLD (MH),
    .TURN_CYC (TC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .req_out     (req_out),
    .req_oe      (req_oe),
    .gnt         (gnt),
    .gpio_out    (gpio_out),
    .gpio_oe     (gpio_oe),
    .owner       (owner),
    .owner_valid (owner_valid),
    .preempt     (preempt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got=%h want=%h", nm, $time, act, exp);
    end
  endtask

  function automatic logic [PW-1:0] slice(input logic [N*PW-1:0] v, input int i);
    return v[i*PW +: PW];
  endfunction

  task automatic model_step();
    logic [N-1:0] others;
    if (rst) begin
      m_owner = -1; m_held = 0; m_gap = 0; m_last = N - 1;
      m_pre = 1'b0; m_out = '0; m_oe = ONES;
    end else begin
      m_pre = 1'b0;
      if (m_owner >= 0) begin
        others = req & ~(N'(1) << m_owner);
        if (!req[m_owner] || (m_held >= MH - 1 && others != '0)) begin
          m_pre   = req[m_owner];
          m_owner = -1;
          m_gap   = TC;
          m_out   = '0;
          m_oe    = ONES;
        end else begin
          m_out  = slice(req_out, m_owner);
          m_oe   = slice(req_oe, m_owner);
          m_held = m_held + 1;
        end
      end else if (m_gap > 0) begin
        m_gap = m_gap - 1;
      end else begin
        m_out = '0;
        m_oe  = ONES;
        for (int k = 1; k <= N; k++) begin
          if (m_owner < 0 && req[(m_last + k) % N]) begin
            m_owner = (m_last + k) % N;
          end
        end
        if (m_owner >= 0) begin
          m_last = m_owner;
          m_held = 0;
        end
      end
    end
  endtask

  // One clock: advance the model with the inputs seen at the edge, then compare.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("gnt", 64'(gnt), (m_owner >= 0) ? 64'(N'(1) << m_owner) : 64'd0);
    chk("owner_valid", 64'(owner_valid), 64'(m_owner >= 0));
    if (m_owner >= 0) chk("owner", 64'(owner), 64'(m_owner));
    chk("preempt", 64'(preempt), 64'(m_pre));
    chk("gpio_out", 64'(gpio_out), 64'(m_out));
    chk("gpio_oe", 64'(gpio_oe), 64'(m_oe));
  endtask

  task automatic chk_reset_vals();
    chk("rst_gnt", 64'(gnt), 64'd0);
    chk("rst_owner_valid", 64'(owner_valid), 64'd0);
    chk("rst_owner", 64'(owner), 64'd0);
    chk("rst_preempt", 64'(preempt), 64'd0);
    chk("rst_gpio_out", 64'(gpio_out), 64'd0);
    chk("rst_gpio_oe", 64'(gpio_oe), 64'(ONES));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    tick();
    chk_reset_vals();
    rst = 1'b0;
    chk_en = 1'b1;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      total++;
      if (!$onehot0(gnt)) begin
        bad++;
        $display("FAIL gnt_onehot0 at %0t: got=%b", $time, gnt);
      end
      total++;
      if (!owner_valid && gpio_oe !== ONES) begin
        bad++;
        $display("FAIL oe_float at %0t: got=%h want=%h", $time, gpio_oe, ONES);
      end
    end
  end

  initial begin
    clk = 1'b0; rst = 1'b1; req = '0; req_out = '0; req_oe = '1;
    total = 0; bad = 0; chk_en = 1'b0;
    m_owner = -1; m_held = 0; m_gap = 0; m_last = N - 1;
    m_pre = 1'b0; m_out = '0; m_oe = ONES;

    for (int i = 0; i < N; i++) pv[i] = {2'(i), 32'hC0DE_0000 | 32'(i)};

    // Handover table for four contending requesters: 4 grant + 3 gap cycles each.
    for (int b = 0; b < 5; b++) begin
      for (int c = 0; c < 7; c++) begin
        tbl[b*7 + c].gnt = (c < 4) ? N'(1) << (b % N) : '0;
        tbl[b*7 + c].pre = (c == 4);
        tbl[b*7 + c].oe1 = (c == 0) || (c >= 4);
        tbl[b*7 + c].out = (c >= 1 && c <= 3) ? pv[b % N] : '0;
      end
    end

    // Single requester: grant one cycle after req, drive one cycle later.
    do_reset();
    req_out[0 +: PW] = 34'h2_AAAA_5555;
    req_oe[0 +: PW]  = '0;
    req = 4'b0001;
    tick();
    chk("first_gnt", 64'(gnt), 64'h1);
    chk("first_drive_pending", 64'(gpio_oe), 64'(ONES));
    tick();
    chk("first_out", 64'(gpio_out), 64'h2_AAAA_5555);
    chk("first_oe", 64'(gpio_oe), 64'd0);

    // All four requesting: owners 0,1,2,3,0 with preemption at each handover.
    do_reset();
    for (int i = 0; i < N; i++) req_out[i*PW +: PW] = pv[i];
    req_oe = '0;
    req = 4'b1111;
    for (int i = 0; i < 35; i++) begin
      tick();
      chk($sformatf("tbl%0d_gnt", i), 64'(gnt), 64'(tbl[i].gnt));
      chk($sformatf("tbl%0d_pre", i), 64'(preempt), 64'(tbl[i].pre));
      chk($sformatf("tbl%0d_oe1", i), 64'(gpio_oe == ONES), 64'(tbl[i].oe1));
      chk($sformatf("tbl%0d_out", i), 64'(gpio_out), 64'(tbl[i].out));
    end

    // Lone owner past the hold limit keeps the bank.
    do_reset();
    req = 4'b0100;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("solo_gnt", 64'(gnt), 64'h4);
      chk("solo_pre", 64'(preempt), 64'd0);
    end

    // Release on the timeout cycle is a plain release.
    do_reset();
    req = 4'b1010;
    tick();
    chk("rel_gnt1", 64'(gnt), 64'h2);
    repeat (3) tick();
    req = 4'b1000;
    tick();
    chk("rel_pre", 64'(preempt), 64'd0);
    chk("rel_gnt_off", 64'(gnt), 64'd0);
    tick();
    chk("rel_pre2", 64'(preempt), 64'd0);
    tick();
    tick();
    chk("rel_gnt3", 64'(gnt), 64'h8);

    // Reset in the middle of a grant restarts priority at requester 0.
    do_reset();
    req = 4'b0100;
    tick();
    chk("mid_gnt2", 64'(gnt), 64'h4);
    tick();
    req = 4'b0101;
    tick();
    rst = 1'b1;
    tick();
    chk_reset_vals();
    rst = 1'b0;
    tick();
    chk("mid_gnt0", 64'(gnt), 64'h1);

    // Randomized traffic with occasional resets.
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(0, 11) == 0) req[b] = ~req[b];
      end
      req_out = (N*PW)'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
      req_oe  = (N*PW)'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
      tick();
    end
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
